// File: rtl/mem_bridge_pkg.sv
// Shared encodings for the data memory bridge: funct3 codes, FSM states, access sizes.
package mem_bridge_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  // Access size is funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Unshifted byte mask for an access size; 11 (never legal) yields no bytes
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane steering: byte masks and shifted store data across two words,
// legality/alignment flags, and load data extraction with sign/zero extension.
module mem_align_unit
  import mem_bridge_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  output logic [7:0]  o_mask8,
  output logic [63:0] o_wfull,
  output logic        o_misaligned,
  output logic        o_illegal,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_size;
  logic [4:0]  w_shamt;
  logic [31:0] w_rshift;

  assign w_size   = i_funct3[1:0];
  assign w_shamt  = {i_off, 3'b000};
  assign o_mask8  = {4'b0000, size_mask(w_size)} << i_off;
  assign o_wfull  = {32'h0, i_wdata} << w_shamt;
  assign w_rshift = 32'({i_word1, i_word0} >> w_shamt);

  // Half at offset 1 stays inside one word, so only offset 3 crosses
  assign o_misaligned = ((w_size == SZ_H) && (i_off == 2'd3)) ||
                        ((w_size == SZ_W) && (i_off != 2'd0));
  assign o_illegal    = i_we ? (i_funct3 > F3_W)
                             : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));

  // Truncate the realigned word to the access size and extend
  always_comb begin
    o_rdata = w_rshift;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
      F3_H:    o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
      F3_BU:   o_rdata = {24'h0, w_rshift[7:0]};
      F3_HU:   o_rdata = {16'h0, w_rshift[15:0]};
      default: o_rdata = w_rshift;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// RV32 load/store bridge to a word-organised, variable-latency data memory.
// One memory request outstanding; misaligned accesses become two word transactions.
module data_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic        core_req_we,
  input  logic [2:0]  core_req_funct3,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_wdata,
  output logic        core_resp_valid,
  output logic [31:0] core_resp_rdata,
  output logic        core_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  state_e      r_state, w_next;
  logic        r_we, r_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [29:0] r_waddr;
  logic [7:0]  r_mask8;
  logic [63:0] r_wfull;
  logic [31:0] r_word0, r_word1;

  logic        w_idle, w_accept, w_bad;
  logic        w_we;
  logic [2:0]  w_funct3;
  logic [1:0]  w_off;
  logic [7:0]  w_mask8;
  logic [63:0] w_wfull;
  logic        w_misaligned, w_illegal;
  logic [31:0] w_rdata;

  // The align unit decodes the live request in IDLE and the latched one afterwards
  assign w_idle   = (r_state == S_IDLE);
  assign w_we     = w_idle ? core_req_we : r_we;
  assign w_funct3 = w_idle ? core_req_funct3 : r_funct3;
  assign w_off    = w_idle ? core_req_addr[1:0] : r_off;
  assign w_accept = core_req_valid && core_req_ready;
  assign w_bad    = w_illegal || (w_misaligned && (MISALIGN_EN == 1'b0));

  mem_align_unit u_align (
    .i_we         (w_we),
    .i_funct3     (w_funct3),
    .i_off        (w_off),
    .i_wdata      (core_req_wdata),
    .i_word0      (r_word0),
    .i_word1      (r_word1),
    .o_mask8      (w_mask8),
    .o_wfull      (w_wfull),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal),
    .o_rdata      (w_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Request capture on accept, read words captured only in the WAIT states
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_waddr  <= 30'h0;
      r_mask8  <= 8'h00;
      r_wfull  <= 64'h0;
      r_word0  <= 32'h0;
      r_word1  <= 32'h0;
    end else begin
      if (w_idle && w_accept) begin
        r_we     <= core_req_we;
        r_err    <= w_bad;
        r_funct3 <= core_req_funct3;
        r_off    <= core_req_addr[1:0];
        r_waddr  <= core_req_addr[31:2];
        r_mask8  <= w_mask8;
        r_wfull  <= w_wfull;
        r_word1  <= 32'h0;
      end
      if ((r_state == S_WAIT0) && mem_resp_valid) r_word0 <= mem_resp_rdata;
      if ((r_state == S_WAIT1) && mem_resp_valid) r_word1 <= mem_resp_rdata;
    end
  end

  // Next state and state-decoded outputs; memory outputs depend only on registers
  always_comb begin
    w_next          = r_state;
    core_req_ready  = 1'b0;
    core_resp_valid = 1'b0;
    core_resp_rdata = 32'h0;
    core_resp_err   = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_req_addr    = 32'h0;
    mem_req_be      = 4'h0;
    mem_req_wdata   = 32'h0;
    case (r_state)
      S_IDLE: begin
        core_req_ready = !rst;
        if (w_accept) w_next = w_bad ? S_RESP : S_REQ0;
      end
      S_REQ0: begin
        mem_req_valid = 1'b1;
        mem_req_we    = r_we;
        mem_req_addr  = {r_waddr, 2'b00};
        mem_req_be    = r_we ? r_mask8[3:0] : 4'hF;
        mem_req_wdata = r_wfull[31:0];
        if (mem_req_ready) w_next = S_WAIT0;
      end
      S_WAIT0: begin
        if (mem_resp_valid) w_next = (r_mask8[7:4] != 4'h0) ? S_REQ1 : S_RESP;
      end
      S_REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_we    = r_we;
        mem_req_addr  = {r_waddr + 30'd1, 2'b00};
        mem_req_be    = r_we ? r_mask8[7:4] : 4'hF;
        mem_req_wdata = r_wfull[63:32];
        if (mem_req_ready) w_next = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_resp_valid) w_next = S_RESP;
      end
      S_RESP: begin
        core_resp_valid = 1'b1;
        core_resp_err   = r_err;
        core_resp_rdata = (r_we || r_err) ? 32'h0 : w_rdata;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: table of load/store vectors against a byte-enable memory
// model, scoreboard queues for memory requests and core responses, plus reset,
// stall and no-split corner sequences.
module tb_data_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        core_req_valid, core_req_ready, core_req_we;
  logic [2:0]  core_req_funct3;
  logic [31:0] core_req_addr, core_req_wdata;
  logic        core_resp_valid, core_resp_err;
  logic [31:0] core_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  logic        c0_req_valid, c0_req_ready, c0_resp_valid, c0_resp_err;
  logic [31:0] c0_resp_rdata;
  logic        m0_req_valid, m0_req_we, m0_req_ready, m0_resp_valid;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_resp_rdata;
  logic [3:0]  m0_req_be;

  data_mem_bridge #(.MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_funct3(core_req_funct3),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata),
    .core_resp_err(core_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  data_mem_bridge #(.MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .core_req_valid(c0_req_valid), .core_req_ready(c0_req_ready),
    .core_req_we(core_req_we), .core_req_funct3(core_req_funct3),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_resp_valid(c0_resp_valid), .core_resp_rdata(c0_resp_rdata),
    .core_resp_err(c0_resp_err),
    .mem_req_valid(m0_req_valid), .mem_req_ready(m0_req_ready),
    .mem_req_we(m0_req_we), .mem_req_addr(m0_req_addr),
    .mem_req_be(m0_req_be), .mem_req_wdata(m0_req_wdata),
    .mem_resp_valid(m0_resp_valid), .mem_resp_rdata(m0_resp_rdata)
  );

  // Memory model: byte-enable writes, response after m_lat cycles (1 = next cycle)
  logic [31:0] mem_arr [256];
  int          m_lat;
  int          m_cnt = 0;
  logic        pre_we;
  logic [31:0] pre_addr, pre_data;

  always @(posedge clk) begin
    mem_resp_valid <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mem_resp_valid <= 1'b1;
    end
    if (mem_req_valid && mem_req_ready) begin
      mem_resp_rdata <= mem_arr[mem_req_addr[9:2]];
      if (mem_req_we)
        for (int b = 0; b < 4; b++)
          if (mem_req_be[b]) mem_arr[mem_req_addr[9:2]][8*b +: 8] <= mem_req_wdata[8*b +: 8];
      if (m_lat <= 1) mem_resp_valid <= 1'b1;
      else            m_cnt <= m_lat - 1;
    end
    if (pre_we) mem_arr[pre_addr[9:2]] <= pre_data;
  end

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } mreq_t;
  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; int stall;
    logic [31:0] rdata; logic err; int lat; int nmem; mreq_t m0; mreq_t m1;
  } vec_t;

  vec_t  vecs[$];
  mreq_t exp_mem_q[$];
  resp_t exp_resp_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic addv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall, input logic [31:0] rd,
                      input logic err, input int lat, input int nmem,
                      input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] d1);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.stall = stall;
    v.rdata = rd; v.err = err; v.lat = lat; v.nmem = nmem;
    v.m0 = '{we, a0, b0, d0};
    v.m1 = '{we, a1, b1, d1};
    vecs.push_back(v);
  endtask

  // Drive one request at a negedge in IDLE; then each negedge handles the mem
  // handshake (with optional initial stall) and the core response, against the queues
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall, input string nm);
    int          k;
    int          stall_left;
    bit          done, snap_v, stable_ok;
    logic [68:0] snap, cur;
    mreq_t       em;
    resp_t       er;
    stall_left = stall; done = 0; snap_v = 0; stable_ok = 1; snap = '0;
    chk({nm, ":idle_ready"}, 32'(core_req_ready), 32'h1);
    core_req_valid = 1'b1; core_req_we = we; core_req_funct3 = f3;
    core_req_addr = addr; core_req_wdata = wd;
    @(negedge clk);
    core_req_valid = 1'b0;
    k = 1;
    while (!done && k < 64) begin
      cur = {mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata};
      if (mem_req_valid) begin
        if (snap_v && cur != snap) stable_ok = 0;
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
          if (!snap_v) begin snap = cur; snap_v = 1; end
        end else begin
          mem_req_ready = 1'b1;
          snap_v = 0;
          if (exp_mem_q.size() == 0) flag_fail({nm, ":unexpected_mem_req"});
          else begin
            em = exp_mem_q.pop_front();
            chk({nm, ":mem_we"},   32'(mem_req_we), 32'(em.we));
            chk({nm, ":mem_addr"}, mem_req_addr, em.addr);
            chk({nm, ":mem_be"},   32'(mem_req_be), 32'(em.be));
            if (em.we) chk({nm, ":mem_wdata"}, mem_req_wdata, em.wdata);
          end
        end
      end
      if (core_resp_valid) begin
        done = 1;
        if (exp_resp_q.size() == 0) flag_fail({nm, ":unexpected_resp"});
        else begin
          er = exp_resp_q.pop_front();
          chk({nm, ":rdata"},   core_resp_rdata, er.rdata);
          chk({nm, ":err"},     32'(core_resp_err), 32'(er.err));
          chk({nm, ":latency"}, k, er.lat);
        end
      end
      @(negedge clk);
      k++;
    end
    mem_req_ready = 1'b1;
    if (!done) begin
      flag_fail({nm, ":timeout_no_resp"});
      exp_resp_q.delete();
    end
    if (stall > 0) chk({nm, ":req_stable_under_stall"}, 32'(stable_ok), 32'h1);
    if (exp_mem_q.size() != 0) begin
      flag_fail({nm, ":missing_mem_req"});
      exp_mem_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    if (v.nmem >= 1) exp_mem_q.push_back(v.m0);
    if (v.nmem >= 2) exp_mem_q.push_back(v.m1);
    exp_resp_q.push_back('{v.rdata, v.err, v.lat});
    run_txn(v.we, v.f3, v.addr, v.wdata, v.stall, nm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen, late;
    rst = 1'b1; core_req_valid = 1'b0; core_req_we = 1'b0; core_req_funct3 = 3'b000;
    core_req_addr = 32'h0; core_req_wdata = 32'h0; mem_req_ready = 1'b1; m_lat = 1;
    pre_we = 1'b0; pre_addr = 32'h0; pre_data = 32'h0;
    c0_req_valid = 1'b0; m0_req_ready = 1'b1; m0_resp_valid = 1'b0; m0_resp_rdata = 32'h0;
    repeat (3) @(negedge clk);

    chk("reset:core_req_ready",  32'(core_req_ready), 32'h0);
    chk("reset:core_resp_valid", 32'(core_resp_valid), 32'h0);
    chk("reset:core_resp_rdata", core_resp_rdata, 32'h0);
    chk("reset:core_resp_err",   32'(core_resp_err), 32'h0);
    chk("reset:mem_req_valid",   32'(mem_req_valid), 32'h0);
    chk("reset:mem_req_we",      32'(mem_req_we), 32'h0);
    chk("reset:mem_req_addr",    mem_req_addr, 32'h0);
    chk("reset:mem_req_be",      32'(mem_req_be), 32'h0);
    chk("reset:mem_req_wdata",   mem_req_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    preload(32'h0000_0100, 32'hDEAD_BEEF);
    preload(32'h0000_0104, 32'h1234_5678);
    preload(32'h0000_0200, 32'h80FF_FF7F);
    preload(32'h0000_0300, 32'h4433_2211);
    preload(32'h0000_0304, 32'h8877_6655);
    preload(32'h0000_0000, 32'hA5A5_A5A5);
    preload(32'hFFFF_FFFC, 32'h5A5A_5A5A);

    //   we f3      addr          wdata        stl rdata         err lat n  m0 addr/be/wd                 m1 addr/be/wd
    addv(0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 0, 3, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b000, 32'h0000_0203, 32'h0,        0, 32'hFFFF_FF80, 0, 3, 1, 32'h0000_0200, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b100, 32'h0000_0203, 32'h0,        0, 32'h0000_0080, 0, 3, 1, 32'h0000_0200, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b001, 32'h0000_0200, 32'h0,        0, 32'hFFFF_FF7F, 0, 3, 1, 32'h0000_0200, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b101, 32'h0000_0201, 32'h0,        0, 32'h0000_FFFF, 0, 3, 1, 32'h0000_0200, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 0, 32'h0,        0, 3, 1, 32'h0000_0100, 4'hC, 32'hABCD_0000, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hABCD_BEEF, 0, 3, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(1, 3'b010, 32'hFFFF_FFFD, 32'h1122_3344, 0, 32'h0,        0, 5, 2, 32'hFFFF_FFFC, 4'hE, 32'h2233_4400, 32'h0, 4'h1, 32'h0000_0011);
    addv(0, 3'b010, 32'h0000_0302, 32'h0,        0, 32'h6655_4433, 0, 5, 2, 32'h0000_0300, 4'hF, 32'h0, 32'h0000_0304, 4'hF, 32'h0);
    addv(0, 3'b001, 32'h0000_0303, 32'h0,        0, 32'h0000_5544, 0, 5, 2, 32'h0000_0300, 4'hF, 32'h0, 32'h0000_0304, 4'hF, 32'h0);
    addv(0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(1, 3'b011, 32'h0000_0100, 32'hFFFF_FFFF, 0, 32'h0,        1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b110, 32'h0000_0100, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(1, 3'b100, 32'h0000_0100, 32'h1234_5678, 0, 32'h0,        1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(1, 3'b000, 32'h0000_0301, 32'hFFFF_FF99, 0, 32'h0,        0, 3, 1, 32'h0000_0300, 4'h2, 32'hFFFF_9900, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b010, 32'h0000_0300, 32'h0,        0, 32'h4433_9911, 0, 3, 1, 32'h0000_0300, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b010, 32'h0000_0101, 32'h0,        3, 32'h78AB_CDBE, 0, 8, 2, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_0104, 4'hF, 32'h0);
    addv(0, 3'b010, 32'hFFFF_FFFC, 32'h0,        0, 32'h2233_445A, 0, 3, 1, 32'hFFFF_FFFC, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);
    addv(0, 3'b010, 32'h0000_0000, 32'h0,        0, 32'hA5A5_A511, 0, 3, 1, 32'h0000_0000, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting on a slow memory: the late response must be dropped
    m_lat = 4;
    chk("rstmid:idle_ready", 32'(core_req_ready), 32'h1);
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_funct3 = 3'b010;
    core_req_addr = 32'h0000_0100; core_req_wdata = 32'h0;
    @(negedge clk);
    core_req_valid = 1'b0;
    chk("rstmid:req0_valid", 32'(mem_req_valid), 32'h1);
    @(negedge clk);
    chk("rstmid:wait0_no_req", 32'(mem_req_valid), 32'h0);
    chk("rstmid:wait0_busy", 32'(core_req_ready), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid:ready_low_in_rst", 32'(core_req_ready), 32'h0);
    chk("rstmid:mem_valid_dropped", 32'(mem_req_valid), 32'h0);
    rst = 1'b0;
    seen = 0; late = 0;
    repeat (8) begin
      @(negedge clk);
      if (core_resp_valid || mem_req_valid) seen = 1;
      if (mem_resp_valid) late = 1;
    end
    chk("rstmid:late_resp_ignored", 32'(seen), 32'h0);
    chk("rstmid:late_resp_seen_by_bench", 32'(late), 32'h1);
    m_lat = 1;
    exp_mem_q.push_back('{1'b0, 32'h0000_0100, 4'hF, 32'h0});
    exp_resp_q.push_back('{32'hABCD_BEEF, 1'b0, 3});
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, "rstmid:after");

    // Misaligned word with splitting disabled: error next cycle, no memory traffic
    chk("nosplit:idle_ready", 32'(c0_req_ready), 32'h1);
    core_req_we = 1'b0; core_req_funct3 = 3'b010; core_req_addr = 32'h0000_0101;
    c0_req_valid = 1'b1;
    @(negedge clk);
    c0_req_valid = 1'b0;
    chk("nosplit:resp_valid", 32'(c0_resp_valid), 32'h1);
    chk("nosplit:resp_err",   32'(c0_resp_err), 32'h1);
    chk("nosplit:resp_rdata", c0_resp_rdata, 32'h0);
    chk("nosplit:no_mem_req", 32'(m0_req_valid), 32'h0);
    @(negedge clk);
    chk("nosplit:resp_one_cycle", 32'(c0_resp_valid), 32'h0);
    chk("nosplit:still_no_mem_req", 32'(m0_req_valid), 32'h0);
    chk("nosplit:back_idle", 32'(c0_req_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
